tile_blit_ctrl: RTL and testbench

TILE_BLIT_CTRL -- requirements
Module: tile_blit_ctrl

---
 rtl/tile_blit_ctrl.sv | 139 +++++++++++++
 tb/tb_tile_blit_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_blit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tile_blit_ctrl
//  Description : Copies one tile from a tile ROM into a linear RGB565
//                framebuffer in raster order. Pixels that fall off-screen
//                are clipped, and pixels equal to the transparent key colour
//                are skipped. The outputs deliver one pixel per clock.
//  Revision    : 1.0  initial release
// ============================================================================
module tile_blit_ctrl #(
    parameter int          TILE_W = 32,
    parameter int          TILE_H = 32,
    parameter int          SCR_W  = 640,
    parameter int          SCR_H  = 480,
    parameter logic [15:0] KEY    = 16'hF81F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  tile_idx,
    input  logic [9:0]  left,
    input  logic [9:0]  top,
    output logic        busy,
    output logic        done,
    output logic [13:0] rom_addr,
    input  logic [15:0] rom_data,
    output logic [18:0] dst_addr,
    output logic [15:0] dst_data,
    output logic        dst_wr
);

    localparam int c_COL_W = $clog2(TILE_W);
    localparam int c_ROW_W = $clog2(TILE_H);

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(TILE_W - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(TILE_H - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_RUN   = 2'd1;
    localparam logic [1:0] c_S_DRAIN = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    logic [1:0]         r_state;
    logic [3:0]         r_tile;
    logic [9:0]         r_left;
    logic [9:0]         r_top;
    logic [c_ROW_W-1:0] r_row;
    logic [c_COL_W-1:0] r_col;

    // Coordinates of the pixel whose ROM word is on rom_data this cycle
    logic               r_p_valid;
    logic [c_ROW_W-1:0] r_p_row;
    logic [c_COL_W-1:0] r_p_col;

    logic [10:0] w_sx;
    logic [10:0] w_sy;
    logic [21:0] w_lin;
    logic        w_on_screen;
    logic        w_wr_en;
    logic        w_last;

    // Address issued to the ROM is the live raster position within the latched tile
    assign rom_addr = 14'({r_tile, r_row, r_col});

    // Screen position of the aligned pixel; 11 bits so left/top + offset never wraps
    assign w_sx        = {1'b0, r_left} + 11'(r_p_col);
    assign w_sy        = {1'b0, r_top}  + 11'(r_p_row);
    assign w_lin       = 22'(w_sy) * 22'(SCR_W) + 22'(w_sx);
    assign w_on_screen = (w_sx < 11'(SCR_W)) && (w_sy < 11'(SCR_H));
    assign w_wr_en     = r_p_valid && w_on_screen && (rom_data != KEY);
    assign w_last      = (r_row == c_ROW_LAST) && (r_col == c_COL_LAST);

    // Control FSM, raster counters, data-alignment stage and registered write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_S_IDLE;
            r_tile    <= '0;
            r_left    <= '0;
            r_top     <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_p_valid <= 1'b0;
            r_p_row   <= '0;
            r_p_col   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dst_wr    <= 1'b0;
            dst_addr  <= '0;
            dst_data  <= '0;
        end else begin
            // ROM latency is one clock, so the pixel coordinates follow one cycle behind
            r_p_valid <= (r_state == c_S_RUN);
            r_p_row   <= r_row;
            r_p_col   <= r_col;

            // Address/data only move on an actual write, otherwise they hold
            dst_wr <= w_wr_en;
            if (w_wr_en) begin
                dst_addr <= w_lin[18:0];
                dst_data <= rom_data;
            end

            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_tile  <= tile_idx;
                        r_left  <= left;
                        r_top   <= top;
                        r_row   <= '0;
                        r_col   <= '0;
                        busy    <= 1'b1;
                        r_state <= c_S_RUN;
                    end
                end
                c_S_RUN: begin
                    // Counters wrap to zero naturally after the final pixel
                    r_col <= r_col + 1'b1;
                    if (r_col == c_COL_LAST) begin
                        r_row <= r_row + 1'b1;
                    end
                    if (w_last) begin
                        r_state <= c_S_DRAIN;
                    end
                end
                c_S_DRAIN: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= c_S_DONE;
                end
                default: begin
                    done    <= 1'b0;
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tile_blit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tile_blit_ctrl
//  Description : Self-checking bench for tile_blit_ctrl. A reference model
//                derives the expected framebuffer write list from the tile
//                contents and placement rules; observed writes are compared.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tile_blit_ctrl;

    localparam int          c_TW   = 32;
    localparam int          c_TH   = 32;
    localparam int          c_SW   = 640;
    localparam int          c_SH   = 480;
    localparam logic [15:0] c_KEY  = 16'hF81F;
    localparam int          c_BLIT = c_TW * c_TH + 2;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  tile_idx;
    logic [9:0]  left;
    logic [9:0]  top;
    logic        busy;
    logic        done;
    logic [13:0] rom_addr;
    logic [15:0] rom_data;
    logic [18:0] dst_addr;
    logic [15:0] dst_data;
    logic        dst_wr;

    int checks   = 0;
    int failures = 0;

    logic [15:0] rom_mem [16384];
    logic [34:0] exp_q[$];
    logic [34:0] obs_q[$];
    int          done_cnt  = 0;
    int          big_addr  = 0;

    tile_blit_ctrl #(
        .TILE_W(c_TW), .TILE_H(c_TH), .SCR_W(c_SW), .SCR_H(c_SH), .KEY(c_KEY)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .tile_idx(tile_idx),
        .left(left), .top(top), .busy(busy), .done(done),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .dst_addr(dst_addr), .dst_data(dst_data), .dst_wr(dst_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous tile ROM with one clock of read latency
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    // Write/done monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst && dst_wr) begin
            obs_q.push_back({dst_addr, dst_data});
            if (dst_addr >= 19'd307200) big_addr++;
        end
        if (!rst && done) done_cnt++;
    end

    // mode 0: random non-key, 1: odd pixels keyed, 2: ~25% keyed
    function automatic void fill_tile(input int t, input int mode);
        for (int p = 0; p < c_TW * c_TH; p++) begin
            logic [15:0] v;
            v = 16'($urandom);
            if (v == c_KEY) v = 16'h0000;
            if (mode == 1 && (p % 2) == 1) v = c_KEY;
            if (mode == 2 && $urandom_range(0, 3) == 0) v = c_KEY;
            rom_mem[t * 1024 + p] = v;
        end
    endfunction

    // Reference: every tile pixel in raster order, kept if on-screen and not the key
    function automatic void build_exp(input int t, input int l, input int tp);
        exp_q.delete();
        for (int r = 0; r < c_TH; r++) begin
            for (int c = 0; c < c_TW; c++) begin
                int sx, sy;
                logic [15:0] d;
                sx = l + c;
                sy = tp + r;
                d  = rom_mem[t * 1024 + r * c_TW + c];
                if (sx < c_SW && sy < c_SH && d != c_KEY)
                    exp_q.push_back({19'(sy * c_SW + sx), d});
            end
        end
    endfunction

    function automatic int first_diff();
        int n;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
        return -1;
    endfunction

    // Starts one blit and returns the cycle (1 = first cycle after the sample edge) done was seen
    task automatic run_blit(input logic [3:0] t, input logic [9:0] l, input logic [9:0] tp,
                            output int cyc);
        build_exp(int'(t), int'(l), int'(tp));
        obs_q.delete();
        done_cnt = 0;
        big_addr = 0;
        @(negedge clk);
        start = 1'b1; tile_idx = t; left = l; top = tp;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        int cyc;
        rst = 1'b1; start = 1'b0; tile_idx = '0; left = '0; top = '0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0)     begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (dst_wr !== 1'b0)   begin failures++; $display("FAIL reset_dst_wr got=%b want=0", dst_wr); end
        checks++; if (dst_addr !== 19'd0) begin failures++; $display("FAIL reset_dst_addr got=%0d want=0", dst_addr); end
        checks++; if (dst_data !== 16'd0) begin failures++; $display("FAIL reset_dst_data got=%h want=0", dst_data); end
        checks++; if (rom_addr !== 14'd0) begin failures++; $display("FAIL reset_rom_addr got=%h want=0", rom_addr); end
        // Start presented together with reset release must be taken on the first edge
        fill_tile(5, 0);
        rst = 1'b0; start = 1'b1; tile_idx = 4'd5; left = 10'd0; top = 10'd0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL first_start_busy got=%b want=1", busy); end
        checks++; if (rom_addr !== 14'h1400) begin failures++; $display("FAIL first_rom_addr got=%h want=1400", rom_addr); end
        cyc = 1;
        while (!done && cyc < 3000) begin @(negedge clk); cyc++; end
        checks++; if (cyc !== c_BLIT) begin failures++; $display("FAIL first_blit_cycles got=%0d want=%0d", cyc, c_BLIT); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc, d;
        fill_tile(0, 0);
        run_blit(4'd0, 10'd320, 10'd240, cyc);
        checks++; if (obs_q.size() !== 1024) begin failures++; $display("FAIL basic_count got=%0d want=1024", obs_q.size()); end
        checks++; if (obs_q.size() == 0 || obs_q[0][34:16] !== 19'd153920)
            begin failures++; $display("FAIL basic_first_addr got=%0d want=153920", obs_q.size() ? obs_q[0][34:16] : 0); end
        checks++; if (obs_q.size() == 0 || obs_q[obs_q.size()-1][34:16] !== exp_q[exp_q.size()-1][34:16])
            begin failures++; $display("FAIL basic_last_addr want=%0d", exp_q[exp_q.size()-1][34:16]); end
        d = first_diff();
        checks++; if (d >= 0) begin failures++; $display("FAIL basic_data idx=%0d got=%h want=%h", d, obs_q[d], exp_q[d]); end
        checks++; if (cyc !== c_BLIT) begin failures++; $display("FAIL basic_cycles got=%0d want=%0d", cyc, c_BLIT); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL basic_done_pulses got=%0d want=1", done_cnt); end
    endtask

    task automatic test_clip();
        int cyc, d;
        fill_tile(7, 0);
        run_blit(4'd7, 10'd620, 10'd470, cyc);
        checks++; if (obs_q.size() !== 200) begin failures++; $display("FAIL clip_count got=%0d want=200", obs_q.size()); end
        d = first_diff();
        checks++; if (d >= 0 || obs_q.size() != exp_q.size())
            begin failures++; $display("FAIL clip_data idx=%0d got_n=%0d want_n=%0d", d, obs_q.size(), exp_q.size()); end
        checks++; if (big_addr !== 0) begin failures++; $display("FAIL clip_oob_addr got=%0d want=0", big_addr); end
        checks++; if (cyc !== c_BLIT) begin failures++; $display("FAIL clip_cycles got=%0d want=%0d", cyc, c_BLIT); end
    endtask

    task automatic test_transparency();
        int cyc, keyed;
        fill_tile(2, 1);
        run_blit(4'd2, 10'd320, 10'd240, cyc);
        keyed = 0;
        foreach (obs_q[i]) if (obs_q[i][15:0] == c_KEY) keyed++;
        checks++; if (obs_q.size() !== 512) begin failures++; $display("FAIL transp_count got=%0d want=512", obs_q.size()); end
        checks++; if (keyed !== 0) begin failures++; $display("FAIL transp_key_written got=%0d want=0", keyed); end
        checks++; if (first_diff() >= 0) begin failures++; $display("FAIL transp_data idx=%0d", first_diff()); end
        checks++; if (cyc !== c_BLIT) begin failures++; $display("FAIL transp_cycles got=%0d want=%0d", cyc, c_BLIT); end
    endtask

    task automatic test_offscreen();
        int cyc;
        fill_tile(9, 0);
        run_blit(4'd9, 10'd700, 10'd100, cyc);
        checks++; if (obs_q.size() !== 0) begin failures++; $display("FAIL offscreen_count got=%0d want=0", obs_q.size()); end
        checks++; if (cyc !== c_BLIT) begin failures++; $display("FAIL offscreen_cycles got=%0d want=%0d", cyc, c_BLIT); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            int cyc, d, t, l, tp;
            t  = $urandom_range(0, 15);
            l  = $urandom_range(0, 1023);
            tp = $urandom_range(0, 1023);
            if (n < 4) begin l = $urandom_range(0, 660); tp = $urandom_range(0, 500); end
            fill_tile(t, 2);
            run_blit(4'(t), 10'(l), 10'(tp), cyc);
            d = first_diff();
            checks++; if (d >= 0 || obs_q.size() != exp_q.size())
                begin failures++; $display("FAIL rand%0d_writes idx=%0d got_n=%0d want_n=%0d t=%0d l=%0d top=%0d",
                                           n, d, obs_q.size(), exp_q.size(), t, l, tp); end
            checks++; if (cyc !== c_BLIT) begin failures++; $display("FAIL rand%0d_cycles got=%0d want=%0d", n, cyc, c_BLIT); end
        end
    endtask

    task automatic test_start_ignored();
        int cyc, d;
        logic [3:0] tile_at_200;
        fill_tile(4, 0);
        fill_tile(11, 0);
        build_exp(4, 100, 50);
        obs_q.delete();
        done_cnt = 0;
        tile_at_200 = '0;
        @(negedge clk);
        start = 1'b1; tile_idx = 4'd4; left = 10'd100; top = 10'd50;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 100) begin start = 1'b1; tile_idx = 4'd11; left = 10'd7; top = 10'd9; end
            if (cyc == 101) start = 1'b0;
            if (cyc == 200) tile_at_200 = rom_addr[13:10];
        end
        repeat (20) @(negedge clk);
        d = first_diff();
        checks++; if (d >= 0 || obs_q.size() != exp_q.size())
            begin failures++; $display("FAIL ignore_writes idx=%0d got_n=%0d want_n=%0d", d, obs_q.size(), exp_q.size()); end
        checks++; if (tile_at_200 !== 4'd4) begin failures++; $display("FAIL ignore_tile got=%0d want=4", tile_at_200); end
        checks++; if (cyc !== c_BLIT) begin failures++; $display("FAIL ignore_cycles got=%0d want=%0d", cyc, c_BLIT); end
        checks++; if (done_cnt !== 1) begin failures++; $display("FAIL ignore_done_pulses got=%0d want=1", done_cnt); end
    endtask

    task automatic test_rst_mid();
        int cyc, d;
        fill_tile(6, 0);
        obs_q.delete();
        done_cnt = 0;
        @(negedge clk);
        start = 1'b1; tile_idx = 4'd6; left = 10'd10; top = 10'd10;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (499) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (dst_wr !== 1'b0) begin failures++; $display("FAIL rstmid_dst_wr got=%b want=0", dst_wr); end
        checks++; if (busy !== 1'b0)   begin failures++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        obs_q.delete();
        repeat (1100) @(negedge clk);
        checks++; if (done_cnt !== 0)     begin failures++; $display("FAIL rstmid_done got=%0d want=0", done_cnt); end
        checks++; if (obs_q.size() !== 0) begin failures++; $display("FAIL rstmid_writes got=%0d want=0", obs_q.size()); end
        run_blit(4'd6, 10'd40, 10'd300, cyc);
        d = first_diff();
        checks++; if (d >= 0 || obs_q.size() != exp_q.size())
            begin failures++; $display("FAIL rstmid_reblit idx=%0d got_n=%0d want_n=%0d", d, obs_q.size(), exp_q.size()); end
        checks++; if (cyc !== c_BLIT) begin failures++; $display("FAIL rstmid_cycles got=%0d want=%0d", cyc, c_BLIT); end
    endtask

    task automatic test_back_to_back();
        int cyc, n_done, bad_tile;
        int done_at[3];
        fill_tile(3, 0);
        n_done = 0;
        bad_tile = 0;
        @(negedge clk);
        start = 1'b1; tile_idx = 4'd3; left = 10'd200; top = 10'd100;
        @(posedge clk);
        @(negedge clk);
        cyc = 1;
        while (n_done < 3 && cyc < 5000) begin
            if (rom_addr[13:10] != 4'd3) bad_tile++;
            if (done) begin done_at[n_done] = cyc; n_done++; end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        checks++; if (n_done !== 3) begin failures++; $display("FAIL b2b_done_count got=%0d want=3", n_done); end
        checks++; if (n_done < 1 || done_at[0] !== c_BLIT)
            begin failures++; $display("FAIL b2b_first_done got=%0d want=%0d", done_at[0], c_BLIT); end
        checks++; if (n_done < 2 || done_at[1] - done_at[0] !== c_BLIT + 1)
            begin failures++; $display("FAIL b2b_period1 got=%0d want=%0d", done_at[1] - done_at[0], c_BLIT + 1); end
        checks++; if (n_done < 3 || done_at[2] - done_at[1] !== c_BLIT + 1)
            begin failures++; $display("FAIL b2b_period2 got=%0d want=%0d", done_at[2] - done_at[1], c_BLIT + 1); end
        checks++; if (bad_tile !== 0) begin failures++; $display("FAIL b2b_tile_bits got=%0d want=0", bad_tile); end
        cyc = 0;
        while (!done && cyc < 3000) begin @(negedge clk); cyc++; end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tile_idx = '0; left = '0; top = '0;
        for (int i = 0; i < 16384; i++) rom_mem[i] = 16'h0000;
        test_reset();
        test_basic();
        test_clip();
        test_transparency();
        test_offscreen();
        test_random();
        test_start_ignored();
        test_rst_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
